data_cache: RTL
===============

# data_cache

Direct-mapped, write-through, no-write-allocate data cache between the CPU memory stage and the word-wide backing data memory. It serves loads combinationally on a hit and raises `stall` to freeze the pipeline on misses and stores. On a read miss it runs a single-word fill from backing memory. Hit and miss counters support performance checks.

## Interface
Parameters:
- `SETS`, 16, number of lines; power of two, ≥2; `IDX_W = $clog2(SETS)`, `TAG_W = 30 - IDX_W`

Ports:
- Clock/reset: one clock; reset is synchronous and active-high.
- `CLK`  in  1  clock
- `rst`  in  1  synchronous active-high reset
- `rd_en`  in  1  load request from memory stage
- `wr_en`  in  1  store request; takes priority over `rd_en`
- `addr`  in  32  byte address (the ALU result)
- `type_i`  in  3  funct3-style access type: 000 B, 001 H, 010 W, 100 BU, 101 HU
- `wdata`  in  32  store data, right-aligned
- `flush`  in  1  invalidate all lines
- `rdata`  out  32  load data, aligned and sign/zero-extended
- `stall`  out  1  hold the pipeline while high
- `mem_req`  out  1  backing-memory request (registered)
- `mem_we`  out  1  1 = write, 0 = read (registered)
- `mem_addr`  out  32  word address, `[1:0] = 0`
- `mem_wdata`  out  32  lane-shifted store data
- `mem_be`  out  4  byte enables for writes
- `mem_ready`  in  1  single-cycle completion pulse
- `mem_rdata`  in  32  fill data, valid with `mem_ready`
- `hit_count`, `miss_count`  out  32  saturating statistics

## Operation
- Address split: `tag = addr[31:2+IDX_W]`, `idx = addr[2+IDX_W-1:2]`, `lane = addr[1:0]`.
- Alignment is forced: halfword accesses ignore `addr[0]`; word accesses ignore `addr[1:0]`.
- Storage: `valid[SETS]`, `tag[SETS]`, `data[SETS]` (32-bit). Hit = `valid[idx] && tag match`.
- FSM states:
  - IDLE:
    - Load hit: `rdata` valid in the same cycle, `stall = 0`, `hit_count++`.
    - Load miss: `stall = 1`, `miss_count++`, go to FILL.
    - Store: `stall = 1`, go to WRITE, unless `ack_q` is set (see below).
  - FILL: `mem_req = 1`, `mem_we = 0`. On `mem_ready`, write the line (valid, tag, data) and return to IDLE. The replayed load then hits, and that hit is not counted.
  - WRITE: `mem_req = 1`, `mem_we = 1`, `mem_be` from type and lane. On `mem_ready`, merge bytes into the line if it hits (no allocate on miss), set `ack_q`, and return to IDLE.
- `ack_q` is a one-cycle flag. In IDLE with `ack_q = 1`, the held store completes with `stall = 0` and is not reissued.
- `stall` is high in FILL and WRITE regardless of `mem_ready`.
- `flush`:
  - In any state, clears all valid bits at the next edge.
  - A fill that completes in the same cycle as `flush` leaves the line invalid.
  - An in-flight memory transaction still completes.
- `rd_en` and `wr_en` both high: treated as a store.
- Counters saturate at `0xFFFF_FFFF`.

## Timing
- Reset (synchronous): state IDLE, all valid bits 0, `ack_q` 0, `mem_req`/`mem_we` 0, `mem_be` 0, counters 0.
- With no request pending after reset, `stall = 0` and `rdata = 0`.
- Load hit latency: 0 cycles (combinational).
- Load miss, with `mem_ready` arriving N cycles after `mem_req` rises: `stall` high for N+1 cycles, data on cycle N+2.
- Store: `stall` high for N+1 cycles, then low for the `ack_q` cycle.
- `mem_req` rises the cycle after the miss or store is detected and is held until `mem_ready`. It drops the cycle after `mem_ready`.
- `mem_addr`, `mem_wdata` and `mem_be` are latched when entering FILL or WRITE and stay stable while `mem_req` is high.
- `mem_ready` outside FILL/WRITE is ignored.
- Reset mid-FILL or mid-WRITE: return to IDLE and drop `mem_req` at the reset edge. The partial transaction is abandoned and no line is written.

## Structure
- Package `cache_pkg`:
  - `mem_type_t` enum (B/H/W/BU/HU encodings)
  - `cache_state_t` enum (IDLE, FILL, WRITE)
  - byte-enable constants
- Sub-module `cache_lane_align` (combinational), used for both the `rdata` path and the `mem_wdata`/`mem_be` and line-merge paths:
  - load extract/extend from word and lane
  - store shift plus `be` generation

## Test plan
- Load miss after reset: LW `0x100`, memory returns `0xDEADBEEF` with N=3 → `stall` high 4 cycles, then `rdata = 0xDEADBEEF`, `miss_count = 1`. Reload `0x100` → 0-cycle hit, `hit_count = 1`.
- Byte/half extension: line holds `0x80FF7F01`.
  - LB `0x103` → `0xFFFFFF80`
  - LBU `0x103` → `0x00000080`
  - LH `0x102` → `0xFFFF80FF`
  - LHU `0x100` → `0x00007F01`
- Store hit: SB `0x101` with `wdata = 0xAA` → `mem_be = 0010`, `mem_wdata = 0x0000AA00`, one memory write. After `ack_q`, LW `0x100` returns `0x80FFAA01` without stall.
- Store miss: SW `0x200` → memory write occurs, no allocate; LW `0x200` then misses (`miss_count` increments).
- Conflict and flush:
  - LW `0x100`, then LW `0x100 + 4·SETS` → second access evicts the first; `0x100` misses again.
  - `flush` pulse → every subsequent access misses.
- Reset mid-FILL: assert `rst` while `mem_req` is high → `mem_req = 0` the next cycle, line `0x100` invalid; a late `mem_ready` is ignored.

Source files
------------

// File: rtl/cache_pkg.sv
// cache_pkg: shared types and constants for the data cache.
//   mem_type_t    - funct3-style access size/sign encodings
//   cache_state_t - controller states
//   BE_*          - base byte-enable patterns (lane 0)
//   sat_inc       - saturating 32-bit increment for statistics counters
package cache_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;

    typedef enum logic [2:0] {
        MT_B  = 3'b000,
        MT_H  = 3'b001,
        MT_W  = 3'b010,
        MT_BU = 3'b100,
        MT_HU = 3'b101
    } mem_type_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_WRITE = 2'd2
    } cache_state_t;

    localparam logic [BE_W-1:0] BE_BYTE = 4'b0001;
    localparam logic [BE_W-1:0] BE_HALF = 4'b0011;
    localparam logic [BE_W-1:0] BE_WORD = 4'b1111;

    // Counter increment that sticks at all-ones.
    function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v);
        return (v == '1) ? v : v + DATA_W'(1);
    endfunction

endpackage

// File: rtl/data_cache_if.sv
// data_cache_if: CPU-side request/response and backing-memory signals.
//   CPU side : rd_en, wr_en, addr, type_i, wdata, flush -> rdata, stall
//   Memory   : mem_req, mem_we, mem_addr, mem_wdata, mem_be <- mem_ready, mem_rdata
//   Stats    : hit_count, miss_count
//   master = CPU/memory environment, slave = cache.
interface data_cache_if;

    logic        rd_en;
    logic        wr_en;
    logic [31:0] addr;
    logic [2:0]  type_i;
    logic [31:0] wdata;
    logic        flush;
    logic [31:0] rdata;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    modport master (
        output rd_en, wr_en, addr, type_i, wdata, flush, mem_ready, mem_rdata,
        input  rdata, stall, mem_req, mem_we, mem_addr, mem_wdata, mem_be,
               hit_count, miss_count
    );

    modport slave (
        input  rd_en, wr_en, addr, type_i, wdata, flush, mem_ready, mem_rdata,
        output rdata, stall, mem_req, mem_we, mem_addr, mem_wdata, mem_be,
               hit_count, miss_count
    );

endinterface

// File: rtl/cache_lane_align.sv
// cache_lane_align: combinational byte-lane steering.
//   type_i/lane_i  - access type and addr[1:0]
//   line_i         - cached word; ld_data_o is the aligned, extended load value
//   st_data_i      - right-aligned store data; st_word_o/st_be_o are lane-shifted
module cache_lane_align
    import cache_pkg::*;
(
    input  logic [2:0]        type_i,
    input  logic [1:0]        lane_i,
    input  logic [DATA_W-1:0] line_i,
    input  logic [DATA_W-1:0] st_data_i,
    output logic [DATA_W-1:0] ld_data_o,
    output logic [DATA_W-1:0] st_word_o,
    output logic [BE_W-1:0]   st_be_o
);

    logic [1:0]        lane_eff;
    logic [DATA_W-1:0] shifted;

    always_comb begin
        lane_eff  = 2'b00;
        ld_data_o = line_i;
        st_word_o = st_data_i;
        st_be_o   = BE_WORD;

        // Halfwords drop addr[0], words drop addr[1:0].
        case (type_i)
            MT_B, MT_BU: lane_eff = lane_i;
            MT_H, MT_HU: lane_eff = {lane_i[1], 1'b0};
            default:     lane_eff = 2'b00;
        endcase

        shifted = line_i >> {lane_eff, 3'b000};

        case (type_i)
            MT_B, MT_BU: begin
                ld_data_o = (type_i == MT_B) ? {{24{shifted[7]}}, shifted[7:0]}
                                             : {24'd0, shifted[7:0]};
                st_word_o = {24'd0, st_data_i[7:0]} << {lane_eff, 3'b000};
                st_be_o   = BE_BYTE << lane_eff;
            end
            MT_H, MT_HU: begin
                ld_data_o = (type_i == MT_H) ? {{16{shifted[15]}}, shifted[15:0]}
                                             : {16'd0, shifted[15:0]};
                st_word_o = {16'd0, st_data_i[15:0]} << {lane_eff, 3'b000};
                st_be_o   = BE_HALF << lane_eff;
            end
            default: begin
                ld_data_o = line_i;
                st_word_o = st_data_i;
                st_be_o   = BE_WORD;
            end
        endcase
    end

endmodule

// File: rtl/data_cache.sv
// data_cache: direct-mapped, write-through, no-write-allocate data cache.
//   CLK, rst - clock and synchronous active-high reset
//   bus      - CPU load/store port, backing-memory port and hit/miss counters
// Load hits return data combinationally; misses fill one word, stores write
// through and merge into the line only when it is already present.
module data_cache
    import cache_pkg::*;
#(
    parameter int unsigned SETS = 16
) (
    input  logic        CLK,
    input  logic        rst,
    data_cache_if.slave bus
);

    localparam int unsigned IDX_W = $clog2(SETS);
    localparam int unsigned TAG_W = 30 - IDX_W;

    cache_state_t      state_q, state_d;
    logic [SETS-1:0]   valid_q, valid_d;
    logic [TAG_W-1:0]  tag_q  [SETS];
    logic [DATA_W-1:0] data_q [SETS];
    logic              ack_q, ack_d;
    logic              replay_q, replay_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [31:0]       mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [BE_W-1:0]   mem_be_q, mem_be_d;
    logic [31:0]       hit_cnt_q, hit_cnt_d;
    logic [31:0]       miss_cnt_q, miss_cnt_d;

    logic              line_we;
    logic [IDX_W-1:0]  line_idx;
    logic [TAG_W-1:0]  line_tag;
    logic [DATA_W-1:0] line_data;
    logic [DATA_W-1:0] merged;
    logic              stall_c;
    logic [DATA_W-1:0] rdata_c;

    // CPU-side and in-flight address decode.
    logic [IDX_W-1:0]  cpu_idx, mem_idx;
    logic [TAG_W-1:0]  cpu_tag, mem_tag;
    logic              cpu_hit, mem_hit;
    logic [DATA_W-1:0] ld_data, st_word;
    logic [BE_W-1:0]   st_be;

    assign cpu_idx = bus.addr[2+IDX_W-1:2];
    assign cpu_tag = bus.addr[31:2+IDX_W];
    assign cpu_hit = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);
    assign mem_idx = mem_addr_q[2+IDX_W-1:2];
    assign mem_tag = mem_addr_q[31:2+IDX_W];
    assign mem_hit = valid_q[mem_idx] && (tag_q[mem_idx] == mem_tag);

    cache_lane_align u_align (
        .type_i    (bus.type_i),
        .lane_i    (bus.addr[1:0]),
        .line_i    (data_q[cpu_idx]),
        .st_data_i (bus.wdata),
        .ld_data_o (ld_data),
        .st_word_o (st_word),
        .st_be_o   (st_be)
    );

    // Byte merge of a completed store into a resident line.
    always_comb begin
        merged = data_q[mem_idx];
        for (int i = 0; i < BE_W; i++) begin
            if (mem_be_q[i]) merged[8*i +: 8] = mem_wdata_q[8*i +: 8];
        end
    end

    // Next-state, memory request and counter logic.
    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        ack_d       = 1'b0;
        replay_d    = 1'b0;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        line_we     = 1'b0;
        line_idx    = mem_idx;
        line_tag    = mem_tag;
        line_data   = bus.mem_rdata;
        stall_c     = 1'b0;
        rdata_c     = '0;

        case (state_q)
            ST_IDLE: begin
                if (bus.wr_en) begin
                    // ack_q marks the held store as already written through.
                    if (!ack_q) begin
                        stall_c     = 1'b1;
                        state_d     = ST_WRITE;
                        mem_req_d   = 1'b1;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = {bus.addr[31:2], 2'b00};
                        mem_wdata_d = st_word;
                        mem_be_d    = st_be;
                    end
                end else if (bus.rd_en) begin
                    if (cpu_hit) begin
                        rdata_c = ld_data;
                        // The replay right after a fill was already counted as a miss.
                        if (!replay_q) hit_cnt_d = sat_inc(hit_cnt_q);
                    end else begin
                        stall_c    = 1'b1;
                        miss_cnt_d = sat_inc(miss_cnt_q);
                        state_d    = ST_FILL;
                        mem_req_d  = 1'b1;
                        mem_we_d   = 1'b0;
                        mem_addr_d = {bus.addr[31:2], 2'b00};
                        mem_be_d   = '0;
                    end
                end
            end
            ST_FILL: begin
                stall_c = 1'b1;
                if (bus.mem_ready) begin
                    line_we           = 1'b1;
                    line_data         = bus.mem_rdata;
                    valid_d[mem_idx]  = 1'b1;
                    replay_d          = 1'b1;
                    mem_req_d         = 1'b0;
                    state_d           = ST_IDLE;
                end
            end
            ST_WRITE: begin
                stall_c = 1'b1;
                if (bus.mem_ready) begin
                    if (mem_hit) begin
                        line_we   = 1'b1;
                        line_data = merged;
                    end
                    ack_d     = 1'b1;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Flush wins over a fill landing in the same cycle.
        if (bus.flush) valid_d = '0;
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            valid_q     <= '0;
            ack_q       <= 1'b0;
            replay_q    <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            ack_q       <= ack_d;
            replay_q    <= replay_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

    // Tag/data storage needs no reset; validity is tracked in valid_q.
    always_ff @(posedge CLK) begin
        if (line_we && !rst) begin
            tag_q[line_idx]  <= line_tag;
            data_q[line_idx] <= line_data;
        end
    end

    assign bus.rdata      = rdata_c;
    assign bus.stall      = stall_c;
    assign bus.mem_req    = mem_req_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.mem_be     = mem_be_q;
    assign bus.hit_count  = hit_cnt_q;
    assign bus.miss_count = miss_cnt_q;

endmodule
